// File: rtl/btn_press_encoder.sv
// btn_press_encoder
//   Conditions the four mode push-buttons: two-flop synchronisation, a counter
//   debounce per channel, a one-hot single-cycle press strobe (highest index
//   wins), and a one-shot long-press strobe for the button that owns the hold.
//
// Ports
//   clk       : system clock
//   rst       : asynchronous reset, active low
//   btn_in    : raw button pins, asynchronous, active high
//   btn_level : debounced button levels (registered)
//   btn_press : one-hot, one-cycle pulse on an accepted press (registered)
//   btn_long  : one-hot, one-cycle pulse when the owning press reaches LONG_CYCLES

// Per-channel synchroniser and debouncer.
module btn_deb #(
    parameter int DEB_CYCLES = 2500000,
    parameter int CNT_WIDTH  = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam logic [CNT_WIDTH-1:0] DC_MAX = CNT_WIDTH'(DEB_CYCLES - 1);

    logic                 s1, s2;
    logic [CNT_WIDTH-1:0] dc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            dc    <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any return to the current level restarts the count, so a glitch
            // shorter than DEB_CYCLES never reaches the level.
            if (s2 == level) begin
                dc <= '0;
            end else if (dc == DC_MAX) begin
                level <= s2;
                dc    <= '0;
            end else begin
                dc <= dc + 1'b1;
            end
        end
    end
endmodule

module btn_press_encoder #(
    parameter int BTN_NUM     = 4,
    parameter int DEB_CYCLES  = 2500000,
    parameter int LONG_CYCLES = 250000000,
    parameter int CNT_WIDTH   = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BTN_NUM-1:0] btn_in,
    output logic [BTN_NUM-1:0] btn_level,
    output logic [BTN_NUM-1:0] btn_press,
    output logic [BTN_NUM-1:0] btn_long
);
    localparam logic [CNT_WIDTH-1:0] HC_MAX = CNT_WIDTH'(LONG_CYCLES - 1);

    logic [BTN_NUM-1:0]   btn_level_d;
    logic [BTN_NUM-1:0]   rise;
    logic [BTN_NUM-1:0]   sel;
    logic [BTN_NUM-1:0]   own;
    logic [CNT_WIDTH-1:0] hc;
    logic                 long_done;
    logic                 own_held;

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_lane
        btn_deb #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_in[i]),
            .level (btn_level[i])
        );
    end

    // Highest rising index wins; lower simultaneous rises are dropped.
    always_comb begin
        rise = btn_level & ~btn_level_d;
        sel  = '0;
        for (int i = 0; i < BTN_NUM; i++) begin
            if (rise[i]) sel = BTN_NUM'(1) << i;
        end
    end

    // own is only ever loaded while its level is high, so "not held" means
    // the owning level has fallen.
    assign own_held = |(own & btn_level);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_level_d <= '0;
            btn_press   <= '0;
            btn_long    <= '0;
            own         <= '0;
            hc          <= '0;
            long_done   <= 1'b0;
        end else begin
            btn_level_d <= btn_level;
            btn_press   <= sel;
            btn_long    <= '0;
            if (|sel) begin
                // A new press takes ownership and suppresses any long strobe
                // the previous owner would have produced this cycle.
                own       <= sel;
                hc        <= '0;
                long_done <= 1'b0;
            end else if (|own) begin
                if (!own_held) begin
                    own       <= '0;
                    hc        <= '0;
                    long_done <= 1'b0;
                end else if (hc == HC_MAX) begin
                    // hc saturates; long_done keeps the strobe to one per press.
                    if (!long_done) begin
                        btn_long  <= own;
                        long_done <= 1'b1;
                    end
                end else begin
                    hc <= hc + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_btn_press_encoder.sv
module tb_btn_press_encoder;
    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_long;

    int n_assert = 0;
    int n_fail   = 0;

    btn_press_encoder #(
        .BTN_NUM     (4),
        .DEB_CYCLES  (4),
        .LONG_CYCLES (16),
        .CNT_WIDTH   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_long  (btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // n cycles with no press and no long strobe expected.
    task automatic quiet(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            chk({tag, "_press"}, btn_press, 4'b0000);
            chk({tag, "_long"}, btn_long, 4'b0000);
        end
    endtask

    initial begin
        rst    = 1'b0;
        btn_in = 4'b0000;

        // 1: reset, then clean press of bit 2
        tick();
        chk("rst_level", btn_level, 4'b0000);
        chk("rst_press", btn_press, 4'b0000);
        chk("rst_long",  btn_long,  4'b0000);
        tick();
        rst = 1'b1;
        quiet(3, "t1_idle");
        btn_in = 4'b0100;
        quiet(5, "t1_pre");
        chk("t1_level_lo", btn_level, 4'b0000);
        quiet(1, "t1_pre6");
        chk("t1_level_hi", btn_level, 4'b0100);
        tick();
        chk("t1_press", btn_press, 4'b0100);
        quiet(1, "t1_post");
        chk("t1_level_hold", btn_level, 4'b0100);
        btn_in = 4'b0000;
        quiet(10, "t1_release");
        chk("t1_level_rel", btn_level, 4'b0000);

        // 2: bounce 3 high / 2 low, then stable high
        for (int p = 0; p < 8; p++) begin
            btn_in[0] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("t2_bounce_press", btn_press, 4'b0000);
                chk("t2_bounce_level", btn_level, 4'b0000);
            end
            btn_in[0] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                tick();
                chk("t2_bounce_press", btn_press, 4'b0000);
                chk("t2_bounce_level", btn_level, 4'b0000);
            end
        end
        btn_in[0] = 1'b1;
        quiet(6, "t2_pre");
        tick();
        chk("t2_press", btn_press, 4'b0001);
        quiet(3, "t2_post");
        btn_in = 4'b0000;
        quiet(10, "t2_release");

        // 3: simultaneous press of bits 3 and 1
        btn_in = 4'b1010;
        quiet(6, "t3_pre");
        tick();
        chk("t3_press", btn_press, 4'b1000);
        chk("t3_level", btn_level, 4'b1010);
        quiet(3, "t3_post");
        btn_in = 4'b0000;
        quiet(10, "t3_release");

        // 4: hold bit 1, bit 3 pressed 8 cycles after press[1] takes ownership
        btn_in = 4'b0010;
        quiet(6, "t4_pre1");
        tick();
        chk("t4_press1", btn_press, 4'b0010);
        quiet(8, "t4_hold1");
        btn_in = 4'b1010;
        quiet(6, "t4_pre3");
        tick();
        chk("t4_press3", btn_press, 4'b1000);
        chk("t4_long_at_press", btn_long, 4'b0000);
        quiet(15, "t4_wait_long");
        tick();
        chk("t4_long3", btn_long, 4'b1000);
        chk("t4_press_at_long", btn_press, 4'b0000);
        quiet(100, "t4_no_repeat");
        btn_in = 4'b0000;
        quiet(10, "t4_release");

        // 5: reset for one cycle 10 cycles into a hold of bit 2
        btn_in = 4'b0100;
        quiet(6, "t5_pre");
        tick();
        chk("t5_press", btn_press, 4'b0100);
        quiet(10, "t5_hold");
        rst = 1'b0;
        #1;
        chk("t5_async_level", btn_level, 4'b0000);
        chk("t5_async_press", btn_press, 4'b0000);
        chk("t5_async_long",  btn_long,  4'b0000);
        tick();
        chk("t5_rst_level", btn_level, 4'b0000);
        rst = 1'b1;
        quiet(6, "t5_repre");
        tick();
        chk("t5_repress", btn_press, 4'b0100);
        quiet(15, "t5_no_stale_long");
        tick();
        chk("t5_long", btn_long, 4'b0100);
        quiet(5, "t5_after_long");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
